// File: rtl/chaining_scoreboard.sv
// Vector chaining scoreboard: tracks per-element writeback progress of
// in-flight writers and flags reads that would see stale elements.
module chaining_scoreboard #(
  parameter int NUM_RECORDS = 4,
  parameter int NUM_READ    = 2,
  parameter int NUM_WB      = 2,
  parameter int OFFSET_W    = 8,
  parameter int WINDOW_REGS = 8,
  parameter int INDEX_W     = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic [4:0]                    alloc_vd,
  input  logic [INDEX_W-1:0]            alloc_instIndex,
  input  logic                          wb_valid [NUM_WB],
  input  logic [INDEX_W-1:0]            wb_instIndex [NUM_WB],
  input  logic [4:0]                    wb_vd [NUM_WB],
  input  logic [OFFSET_W-1:0]           wb_offset [NUM_WB],
  input  logic                          retire_valid,
  input  logic [INDEX_W-1:0]            retire_instIndex,
  input  logic [4:0]                    read_vs [NUM_READ],
  input  logic [OFFSET_W-1:0]           read_offset [NUM_READ],
  input  logic [INDEX_W-1:0]            read_instIndex [NUM_READ],
  output logic                          checkResult [NUM_READ],
  output logic [$clog2(NUM_RECORDS):0]  occupancy,
  output logic                          dup_error
);

  localparam int LW = $clog2(WINDOW_REGS);
  localparam int MW = WINDOW_REGS << OFFSET_W;
  localparam int BW = LW + OFFSET_W;
  localparam int RW = (NUM_RECORDS > 1) ? $clog2(NUM_RECORDS) : 1;
  localparam int CW = $clog2(NUM_RECORDS) + 1;

  logic [NUM_RECORDS-1:0] valid;
  logic [4:0]             vd   [NUM_RECORDS];
  logic [INDEX_W-1:0]     inst [NUM_RECORDS];
  logic [MW-1:0]          mask [NUM_RECORDS];
  logic [MW-1:0]          mask_nxt [NUM_RECORDS];
  logic                   dup;

  logic [RW-1:0]          free_idx;
  logic                   dup_hit;
  logic                   alloc_fire;
  logic [NUM_READ-1:0]    haz;

  function automatic logic in_win(input logic [4:0] vs,
                                  input logic [4:0] base);
    logic [4:0] d;
    d = vs - base;
    return 32'(d) < WINDOW_REGS;
  endfunction

  function automatic logic [BW-1:0] bit_at(
    input logic [4:0]          vs,
    input logic [4:0]          base,
    input logic [OFFSET_W-1:0] off
  );
    logic [4:0] d;
    d = vs - base;
    return {d[LW-1:0], off};
  endfunction

  // a older than b under wrap-around instruction ordering
  function automatic logic older(input logic [INDEX_W-1:0] a,
                                 input logic [INDEX_W-1:0] b);
    return (a[INDEX_W-2:0] < b[INDEX_W-2:0])
           ^ a[INDEX_W-1] ^ b[INDEX_W-1];
  endfunction

  assign alloc_ready = ~&valid;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign dup_error   = dup;

  // Lowest-numbered free record and live-index duplicate detection
  always_comb begin
    free_idx = '0;
    dup_hit  = 1'b0;
    for (int r = NUM_RECORDS - 1; r >= 0; r--) begin
      if (!valid[r]) free_idx = RW'(r);
      if (valid[r] && inst[r] == alloc_instIndex) dup_hit = 1'b1;
    end
  end

  // Merge all writeback ports into each live record's element mask
  always_comb begin
    for (int r = 0; r < NUM_RECORDS; r++) begin
      mask_nxt[r] = mask[r];
      for (int w = 0; w < NUM_WB; w++) begin
        if (wb_valid[w] && valid[r] && wb_instIndex[w] == inst[r]
            && in_win(wb_vd[w], vd[r]))
          mask_nxt[r][bit_at(wb_vd[w], vd[r], wb_offset[w])] = 1'b1;
      end
    end
  end

  // Read hazard check against registered record state only
  always_comb begin
    haz = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      for (int r = 0; r < NUM_RECORDS; r++) begin
        if (valid[r] && inst[r] != read_instIndex[p]
            && !older(read_instIndex[p], inst[r])
            && in_win(read_vs[p], vd[r])
            && !mask[r][bit_at(read_vs[p], vd[r], read_offset[p])])
          haz[p] = 1'b1;
      end
      checkResult[p] = ~haz[p];
    end
  end

  // Population count of live records
  always_comb begin
    occupancy = '0;
    for (int r = 0; r < NUM_RECORDS; r++)
      occupancy = occupancy + CW'(valid[r]);
  end

  // Record state: retire beats writeback, allocation fills a free slot
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= '0;
      dup   <= 1'b0;
      for (int r = 0; r < NUM_RECORDS; r++) begin
        vd[r]   <= '0;
        inst[r] <= '0;
        mask[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_RECORDS; r++) begin
        if (valid[r]) begin
          if (retire_valid && inst[r] == retire_instIndex) begin
            valid[r] <= 1'b0;
            mask[r]  <= '0;
          end else begin
            mask[r] <= mask_nxt[r];
          end
        end
      end
      if (alloc_fire) begin
        valid[free_idx] <= 1'b1;
        vd[free_idx]    <= alloc_vd;
        inst[free_idx]  <= alloc_instIndex;
        mask[free_idx]  <= '0;
        if (dup_hit) dup <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chaining_scoreboard.sv
// Testbench for chaining_scoreboard: directed scenarios plus randomized
// traffic checked against an array-based behavioural model.
module tb_chaining_scoreboard;

  localparam int NR    = 4;
  localparam int NRD   = 2;
  localparam int NWB   = 2;
  localparam int OW    = 8;
  localparam int WR    = 8;
  localparam int IW    = 3;
  localparam int ELEMS = 1 << OW;
  localparam int MW    = WR * ELEMS;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          alloc_valid;
  logic          alloc_ready;
  logic [4:0]    alloc_vd;
  logic [IW-1:0] alloc_instIndex;
  logic          wb_valid [NWB];
  logic [IW-1:0] wb_instIndex [NWB];
  logic [4:0]    wb_vd [NWB];
  logic [OW-1:0] wb_offset [NWB];
  logic          retire_valid;
  logic [IW-1:0] retire_instIndex;
  logic [4:0]    read_vs [NRD];
  logic [OW-1:0] read_offset [NRD];
  logic [IW-1:0] read_instIndex [NRD];
  logic          checkResult [NRD];
  logic [2:0]    occupancy;
  logic          dup_error;

  always #5 clock = ~clock;

  chaining_scoreboard #(
    .NUM_RECORDS(NR), .NUM_READ(NRD), .NUM_WB(NWB),
    .OFFSET_W(OW), .WINDOW_REGS(WR), .INDEX_W(IW)
  ) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_vd(alloc_vd), .alloc_instIndex(alloc_instIndex),
    .wb_valid(wb_valid), .wb_instIndex(wb_instIndex),
    .wb_vd(wb_vd), .wb_offset(wb_offset),
    .retire_valid(retire_valid), .retire_instIndex(retire_instIndex),
    .read_vs(read_vs), .read_offset(read_offset),
    .read_instIndex(read_instIndex), .checkResult(checkResult),
    .occupancy(occupancy), .dup_error(dup_error)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // behavioural model
  bit mv [NR];
  int mvd [NR];
  int midx [NR];
  bit mmask [NR][MW];
  bit mdup;

  // a older than b: b lies 1..half-range ahead of a in wrapped order
  function automatic bit m_older(int a, int b);
    int diff;
    diff = (b - a + (1 << IW)) % (1 << IW);
    return diff >= 1 && diff <= (1 << (IW - 1));
  endfunction

  function automatic int m_dist(int vs, int base);
    return (vs - base + 32) % 32;
  endfunction

  function automatic bit m_safe(int vs, int off, int ridx);
    int d;
    for (int r = 0; r < NR; r++) begin
      if (mv[r] && midx[r] != ridx && !m_older(ridx, midx[r])) begin
        d = m_dist(vs, mvd[r]);
        if (d < WR && !mmask[r][d * ELEMS + off]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic int m_occ();
    int n = 0;
    for (int r = 0; r < NR; r++) n += int'(mv[r]);
    return n;
  endfunction

  task automatic m_clear(int r);
    for (int i = 0; i < MW; i++) mmask[r][i] = 1'b0;
  endtask

  task automatic model_edge();
    bit nv [NR];
    int slot;
    int d;
    if (!reset) begin
      for (int r = 0; r < NR; r++) begin
        mv[r] = 1'b0;
        m_clear(r);
      end
      mdup = 1'b0;
      return;
    end
    slot = -1;
    for (int r = NR - 1; r >= 0; r--) if (!mv[r]) slot = r;
    nv = mv;
    for (int w = 0; w < NWB; w++) begin
      if (!wb_valid[w]) continue;
      for (int r = 0; r < NR; r++) begin
        d = m_dist(int'(wb_vd[w]), mvd[r]);
        if (mv[r] && midx[r] == int'(wb_instIndex[w]) && d < WR)
          mmask[r][d * ELEMS + int'(wb_offset[w])] = 1'b1;
      end
    end
    if (retire_valid)
      for (int r = 0; r < NR; r++)
        if (mv[r] && midx[r] == int'(retire_instIndex)) nv[r] = 1'b0;
    if (alloc_valid && slot >= 0) begin
      for (int r = 0; r < NR; r++)
        if (mv[r] && midx[r] == int'(alloc_instIndex)) mdup = 1'b1;
      nv[slot]   = 1'b1;
      mvd[slot]  = int'(alloc_vd);
      midx[slot] = int'(alloc_instIndex);
      m_clear(slot);
    end
    mv = nv;
  endtask

  task automatic idle();
    alloc_valid      = 1'b0;
    alloc_vd         = '0;
    alloc_instIndex  = '0;
    retire_valid     = 1'b0;
    retire_instIndex = '0;
    for (int w = 0; w < NWB; w++) begin
      wb_valid[w]     = 1'b0;
      wb_instIndex[w] = '0;
      wb_vd[w]        = '0;
      wb_offset[w]    = '0;
    end
    for (int p = 0; p < NRD; p++) begin
      read_vs[p]        = '0;
      read_offset[p]    = '0;
      read_instIndex[p] = '0;
    end
  endtask

  // compare outputs against the model, then advance one clock
  task automatic step();
    #1;
    check("alloc_ready", 32'(alloc_ready), 32'(m_occ() < NR));
    check("occupancy", 32'(occupancy), 32'(m_occ()));
    check("dup_error", 32'(dup_error), 32'(mdup));
    for (int p = 0; p < NRD; p++)
      check($sformatf("checkResult%0d", p), 32'(checkResult[p]),
            32'(m_safe(int'(read_vs[p]), int'(read_offset[p]),
                       int'(read_instIndex[p]))));
    @(posedge clock);
    model_edge();
    @(negedge clock);
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic alloc(int v, int idx);
    alloc_valid     = 1'b1;
    alloc_vd        = 5'(v);
    alloc_instIndex = IW'(idx);
    step();
  endtask

  task automatic set_read(int p, int vs, int off, int idx);
    read_vs[p]        = 5'(vs);
    read_offset[p]    = OW'(off);
    read_instIndex[p] = IW'(idx);
  endtask

  int r;

  initial begin
    idle();
    reset = 1'b0;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_ready", 32'(alloc_ready), 32'd1);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_dup", 32'(dup_error), 32'd0);
    check("rst_chk0", 32'(checkResult[0]), 32'd1);
    check("rst_chk1", 32'(checkResult[1]), 32'd1);

    // element written later clears the hazard
    alloc(4, 1);
    set_read(0, 5, 3, 2);
    #1 check("chain_haz", 32'(checkResult[0]), 32'd0);
    set_read(0, 5, 3, 2);
    wb_valid[0] = 1'b1;
    wb_vd[0] = 5'd5;
    wb_offset[0] = 8'd3;
    wb_instIndex[0] = 3'd1;
    step();
    set_read(0, 5, 3, 2);
    #1 check("chain_ok", 32'(checkResult[0]), 32'd1);
    step();

    // wrap-ordered age comparison
    do_reset();
    alloc(0, 5);
    set_read(0, 0, 0, 4);
    set_read(1, 0, 0, 0);
    #1 check("age_older", 32'(checkResult[0]), 32'd1);
    check("age_wrapped", 32'(checkResult[1]), 32'd0);
    step();

    // full table, retire+alloc in the same cycle
    do_reset();
    for (int i = 0; i < NR; i++) alloc(0, i);
    #1 check("full_ready", 32'(alloc_ready), 32'd0);
    check("full_occ", 32'(occupancy), 32'd4);
    retire_valid = 1'b1;
    retire_instIndex = 3'd0;
    alloc_valid = 1'b1;
    alloc_instIndex = 3'd6;
    step();
    #1 check("ret_occ", 32'(occupancy), 32'd3);
    check("ret_ready", 32'(alloc_ready), 32'd1);
    step();

    // register window wraps modulo 32
    do_reset();
    alloc(30, 1);
    set_read(0, 2, 0, 2);
    set_read(1, 6, 0, 2);
    #1 check("win_wrap", 32'(checkResult[0]), 32'd0);
    check("win_out", 32'(checkResult[1]), 32'd1);
    step();

    // sticky duplicate flag
    do_reset();
    alloc(0, 3);
    alloc(1, 3);
    #1 check("dup_set", 32'(dup_error), 32'd1);
    step();
    #1 check("dup_stay", 32'(dup_error), 32'd1);
    step();
    do_reset();
    #1 check("dup_clr", 32'(dup_error), 32'd0);
    check("dup_occ", 32'(occupancy), 32'd0);
    step();

    // writeback racing a retire is lost; realloc starts clean
    alloc(0, 2);
    wb_valid[0] = 1'b1;
    wb_vd[0] = 5'd0;
    wb_offset[0] = 8'd1;
    wb_instIndex[0] = 3'd2;
    retire_valid = 1'b1;
    retire_instIndex = 3'd2;
    step();
    alloc(0, 2);
    set_read(0, 0, 1, 3);
    #1 check("realloc_haz", 32'(checkResult[0]), 32'd0);
    check("realloc_occ", 32'(occupancy), 32'd1);
    step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) != 0);
      alloc_valid = ($urandom_range(0, 9) < 4);
      alloc_vd = 5'($urandom_range(0, 31));
      alloc_instIndex = IW'($urandom_range(0, 7));
      for (int w = 0; w < NWB; w++) begin
        r = int'($urandom_range(0, NR - 1));
        wb_valid[w] = ($urandom_range(0, 9) < 6);
        wb_offset[w] = OW'($urandom_range(0, 3));
        if (mv[r] && $urandom_range(0, 3) != 0) begin
          wb_instIndex[w] = IW'(midx[r]);
          wb_vd[w] = 5'((mvd[r] + int'($urandom_range(0, 9))) % 32);
        end else begin
          wb_instIndex[w] = IW'($urandom_range(0, 7));
          wb_vd[w] = 5'($urandom_range(0, 31));
        end
      end
      r = int'($urandom_range(0, NR - 1));
      retire_valid = ($urandom_range(0, 99) < 15);
      retire_instIndex = mv[r] ? IW'(midx[r]) : IW'($urandom_range(0, 7));
      for (int p = 0; p < NRD; p++) begin
        r = int'($urandom_range(0, NR - 1));
        read_offset[p] = OW'($urandom_range(0, 3));
        read_instIndex[p] = IW'($urandom_range(0, 7));
        if (mv[r])
          read_vs[p] = 5'((mvd[r] + int'($urandom_range(0, 9))) % 32);
        else
          read_vs[p] = 5'($urandom_range(0, 31));
      end
      step();
    end
    reset = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
